// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers,
// granting bursts of up to BURST accepted writes and throttling on fifo_full.
module fifo_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int BURST = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             fifo_full,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] wr_sel,
  output logic             fifo_wr_en,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
  localparam logic [IDX_W-1:0] LAST_REQ  = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]   N_REQ_EXT = (IDX_W + 1)'(N_REQ);

  state_t             state, state_n;
  logic [IDX_W-1:0]   last_owner, last_owner_n;
  logic [IDX_W-1:0]   wr_sel_n;
  logic [CNT_W-1:0]   beat_cnt_n;
  logic [N_REQ-1:0]   gnt_n;

  logic [IDX_W-1:0]   pick_base;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_hit;
  logic               pick_valid;
  logic [IDX_W:0]     scan_pos;
  logic               hand_off;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      wr_sel     <= '0;
      beat_cnt   <= '0;
      last_owner <= LAST_REQ;
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      wr_sel     <= wr_sel_n;
      beat_cnt   <= beat_cnt_n;
      last_owner <= last_owner_n;
    end
  end

  // Rotating scan: while granted, the current owner becomes the rotation
  // base, so a hand-off starts searching just past it.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves a value unassigned (which would infer a latch).
    pick_base = (state == GRANT) ? wr_sel : last_owner;
    pick_idx  = '0;
    pick_hit  = 1'b0;
    scan_pos  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      scan_pos = {1'b0, pick_base} + (IDX_W + 1)'(i);
      if (scan_pos >= N_REQ_EXT) scan_pos = scan_pos - N_REQ_EXT;
      if (req[scan_pos[IDX_W-1:0]]) begin
        pick_hit = 1'b1;
        pick_idx = scan_pos[IDX_W-1:0];
      end
    end
    pick_valid = pick_hit && !fifo_full;
  end

  always_comb begin
    state_n      = state;
    gnt_n        = gnt;
    wr_sel_n     = wr_sel;
    beat_cnt_n   = beat_cnt;
    last_owner_n = last_owner;
    hand_off     = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n           = GRANT;
          gnt_n             = '0;
          gnt_n[pick_idx]   = 1'b1;
          wr_sel_n          = pick_idx;
          beat_cnt_n        = '0;
        end
      end
      GRANT: begin
        // Release (owner dropped req) outranks a stall; burst end needs an accept.
        hand_off = !req[wr_sel] || (fifo_wr_en && (beat_cnt == LAST_BEAT));
        if (hand_off) begin
          last_owner_n = wr_sel;
          beat_cnt_n   = '0;
          if (pick_valid) begin
            gnt_n           = '0;
            gnt_n[pick_idx] = 1'b1;
            wr_sel_n        = pick_idx;
          end else begin
            state_n  = IDLE;
            gnt_n    = '0;
            wr_sel_n = '0;
          end
        end else if (fifo_wr_en) begin
          beat_cnt_n = beat_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == GRANT);
    fifo_wr_en = busy && req[wr_sel] && !fifo_full;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter, checked every cycle
// against a transaction-level round-robin model kept in integers.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int BURST = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 4;
  localparam int OBS_W = N + IDX_W + CNT_W + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic             fifo_full;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] wr_sel;
  logic             fifo_wr_en;
  logic [CNT_W-1:0] beat_cnt;
  logic             busy;

  logic [OBS_W-1:0] obs;
  logic [OBS_W-1:0] exp_vec;

  int vectors    = 0;
  int miscompares = 0;

  // Reference state: owner index or -1 when idle.
  int m_owner;
  int m_beats;
  int m_last;

  fifo_wr_arbiter #(.N_REQ(N), .BURST(BURST), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .fifo_full  (fifo_full),
    .gnt        (gnt),
    .wr_sel     (wr_sel),
    .fifo_wr_en (fifo_wr_en),
    .beat_cnt   (beat_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign obs = {gnt, wr_sel, beat_cnt, busy, fifo_wr_en};

  function automatic int pick(input int base, input logic [N-1:0] r, input logic f);
    if (f) return -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (base + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [OBS_W-1:0] predict();
    logic [N-1:0]     g = '0;
    logic [IDX_W-1:0] s = '0;
    logic             b = 1'b0;
    logic             w = 1'b0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      s = IDX_W'(m_owner);
      b = 1'b1;
      w = req[m_owner] && !fifo_full;
    end
    return {g, s, CNT_W'(m_beats), b, w};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = N - 1;
  endtask

  // Drive inputs just after a rising edge, then predict at the falling edge.
  task automatic apply(input logic [N-1:0] r, input logic f);
    req       = r;
    fifo_full = f;
    @(negedge clk);
    exp_vec = predict();
  endtask

  // Move the model across the rising edge and land 1 time unit past it.
  task automatic advance();
    logic wr;
    logic rel;
    logic fin;
    int   p;
    if (m_owner < 0) begin
      p = pick(m_last, req, fifo_full);
      if (p >= 0) begin
        m_owner = p;
        m_beats = 0;
      end
    end else begin
      wr  = req[m_owner] && !fifo_full;
      rel = !req[m_owner];
      fin = wr && (m_beats == BURST - 1);
      if (rel || fin) begin
        m_last  = m_owner;
        m_owner = pick(m_owner, req, fifo_full);
        m_beats = 0;
      end else if (wr) begin
        m_beats++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    fifo_full = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req       = 4'b1111;
    fifo_full = 1'b0;
    #2;
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want %h", obs, {OBS_W{1'b0}});
    end
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_held: got %h want %h", obs, {OBS_W{1'b0}});
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    int writes = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      apply(4'b0001, 1'b0);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL single cyc %0d: got %h want %h", c, obs, exp_vec);
      end
      if (fifo_wr_en) writes++;
      advance();
    end
    vectors++;
    if (writes !== 11) begin
      miscompares++;
      $display("FAIL single_writes: got %0d want 11", writes);
    end
  endtask

  task automatic test_round_robin();
    int writes = 0;
    do_reset();
    for (int c = 0; c < 33; c++) begin
      apply(4'b1111, 1'b0);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL rr cyc %0d: got %h want %h", c, obs, exp_vec);
      end
      if (fifo_wr_en) begin
        vectors++;
        if (int'(wr_sel) !== (writes / BURST) % N) begin
          miscompares++;
          $display("FAIL rr_sel write %0d: got %0d want %0d", writes, wr_sel, (writes / BURST) % N);
        end
        writes++;
      end
      advance();
    end
    vectors++;
    if (writes !== 32) begin
      miscompares++;
      $display("FAIL rr_writes: got %0d want 32", writes);
    end
  endtask

  task automatic test_full_stall();
    int post_writes = 0;
    logic f;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      f = (c >= 3 && c <= 5);
      apply(4'b0101, f);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL stall cyc %0d: got %h want %h", c, obs, exp_vec);
      end
      if (f) begin
        vectors++;
        if ({gnt, fifo_wr_en, beat_cnt} !== {4'b0001, 1'b0, 4'd2}) begin
          miscompares++;
          $display("FAIL stall_hold cyc %0d: got gnt=%b wr=%b cnt=%0d want gnt=0001 wr=0 cnt=2",
                   c, gnt, fifo_wr_en, beat_cnt);
        end
      end
      if (c == 6 || c == 7) if (fifo_wr_en && gnt == 4'b0001) post_writes++;
      if (c == 8) begin
        vectors++;
        if (gnt !== 4'b0100) begin
          miscompares++;
          $display("FAIL stall_handoff: got gnt=%b want 0100", gnt);
        end
      end
      advance();
    end
    vectors++;
    if (post_writes !== 2) begin
      miscompares++;
      $display("FAIL stall_post_writes: got %0d want 2", post_writes);
    end
  endtask

  task automatic test_release();
    logic [N-1:0] r;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      r = (c == 7) ? 4'b0001 : 4'b0011;
      apply(r, 1'b0);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL release cyc %0d: got %h want %h", c, obs, exp_vec);
      end
      if (c == 7) begin
        vectors++;
        if ({gnt, fifo_wr_en} !== {4'b0010, 1'b0}) begin
          miscompares++;
          $display("FAIL release_cycle: got gnt=%b wr=%b want gnt=0010 wr=0", gnt, fifo_wr_en);
        end
      end
      if (c == 8) begin
        vectors++;
        if ({gnt, beat_cnt} !== {4'b0001, 4'd0}) begin
          miscompares++;
          $display("FAIL release_handoff: got gnt=%b cnt=%0d want gnt=0001 cnt=0", gnt, beat_cnt);
        end
      end
      advance();
    end
  endtask

  task automatic test_fifo_fill();
    int occ    = 0;
    int writes = 0;
    logic wr;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      apply(4'b1111, occ >= 16);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL fill cyc %0d: got %h want %h", c, obs, exp_vec);
      end
      wr = fifo_wr_en;
      if (occ >= 16) begin
        vectors++;
        if (wr !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_write_while_full cyc %0d: got wr=%b want 0", c, wr);
        end
      end
      advance();
      if (wr) begin
        occ++;
        writes++;
      end
    end
    vectors++;
    if (writes !== 16) begin
      miscompares++;
      $display("FAIL fill_writes: got %0d want 16", writes);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      apply(4'b1111, 1'b0);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL midrst cyc %0d: got %h want %h", c, obs, exp_vec);
      end
      if (c < 10) advance();
    end
    vectors++;
    if ({gnt, beat_cnt} !== {4'b0100, 4'd1}) begin
      miscompares++;
      $display("FAIL midrst_setup: got gnt=%b cnt=%0d want gnt=0100 cnt=1", gnt, beat_cnt);
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL midrst_immediate: got %h want %h", obs, {OBS_W{1'b0}});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      apply(4'b1111, 1'b0);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL midrst_after cyc %0d: got %h want %h", c, obs, exp_vec);
      end
      if (c == 1) begin
        vectors++;
        if (gnt !== 4'b0001) begin
          miscompares++;
          $display("FAIL midrst_first_grant: got gnt=%b want 0001", gnt);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic         f;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = 4'b1111;
      f = ($urandom_range(0, 3) == 0);
      apply(r, f);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL random cyc %0d req=%b full=%b: got %h want %h", c, r, f, obs, exp_vec);
      end
      vectors++;
      if (!$onehot0(gnt) || busy !== (|gnt)) begin
        miscompares++;
        $display("FAIL random_gnt_shape cyc %0d: got gnt=%b busy=%b want onehot0 and busy=|gnt",
                 c, gnt, busy);
      end
      advance();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_release();
    test_fifo_fill();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
